// File: rtl/result_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : result_uart_tx                                               |
// | Description : Sends a 4-bit match result as ASCII '0'|result plus newline  |
// |               over an 8N1 UART line, one message per ready assertion.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       transmit_ready,
  input  logic [3:0] result,
  output logic       tx,
  output logic       busy,
  output logic       sent
);

  localparam int              c_cnt_w     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      c_newline   = 8'h0A;
  localparam logic            c_sel_char  = 1'b0;
  localparam logic            c_sel_nl    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_armed;
  logic [c_cnt_w-1:0]   r_baud_cnt;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_byte_sel;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_sent;
  logic                 w_bit_end;

  assign w_bit_end = (r_baud_cnt == c_baud_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_sel <= c_sel_char;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
          // Re-arming only while idle and low gives one message per assertion.
          if (!transmit_ready) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed    <= 1'b0;
            r_shift    <= {4'b0011, result};
            r_byte_sel <= c_sel_char;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            // Newline frame follows the character with no idle gap.
            if (r_byte_sel == c_sel_char) begin
              r_shift    <= c_newline;
              r_byte_sel <= c_sel_nl;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_sent  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign sent = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_result_uart_tx                                            |
// | Description : Self-checking bench for result_uart_tx with a UART receiver  |
// |               model and a queue of expected bytes.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_result_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       transmit_ready;
  logic [3:0] result;
  logic       tx;
  logic       busy;
  logic       sent;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .reset         (reset),
    .transmit_ready(transmit_ready),
    .result        (result),
    .tx            (tx),
    .busy          (busy),
    .sent          (sent)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Receiver model: called at a negedge; finds the start bit and samples mid-bit.
  task automatic rx_byte(output logic [7:0] data, output logic frame_ok, output logic timed_out);
    int n;
    n = 0;
    data = '0;
    frame_ok = 1'b0;
    timed_out = 1'b0;
    while (tx !== 1'b0) begin
      if (n >= 60 * C) begin
        timed_out = 1'b1;
        return;
      end
      @(negedge clk);
      n++;
    end
    repeat (C / 2) @(negedge clk);
    frame_ok = (tx === 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (C) @(negedge clk);
      data[k] = tx;
    end
    repeat (C) @(negedge clk);
    frame_ok = frame_ok && (tx === 1'b1);
  endtask

  function automatic logic exp_line(int j, logic [7:0] b0, logic [7:0] b1);
    int p;
    logic [7:0] b;
    if (j >= 20 * C) return 1'b1;
    b = (j >= 10 * C) ? b1 : b0;
    p = (j % (10 * C)) / C;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    transmit_ready = 1'b1;
    result = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b expected 0", sent); end
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ready_across_reset: %0d active cycles, expected 0", bad); end
    transmit_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_timing();
    logic [7:0] b0;
    int busy_cycles;
    result = 4'b1010;
    b0 = 8'h30 | {4'h0, result};
    transmit_ready = 1'b1;
    busy_cycles = 0;
    for (int j = 0; j <= 20 * C + 1; j++) begin
      @(negedge clk);
      if (j == 0) transmit_ready = 1'b0;
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (tx !== exp_line(j, b0, 8'h0A)) begin
        errors++; $display("FAIL timing_tx[%0d]: got %b expected %b", j, tx, exp_line(j, b0, 8'h0A));
      end
      checks++;
      if (busy !== (j < 20 * C)) begin
        errors++; $display("FAIL timing_busy[%0d]: got %b expected %b", j, busy, (j < 20 * C));
      end
      checks++;
      if (sent !== (j == 20 * C)) begin
        errors++; $display("FAIL timing_sent[%0d]: got %b expected %b", j, sent, (j == 20 * C));
      end
    end
    checks++;
    if (busy_cycles != 20 * C) begin
      errors++; $display("FAIL busy_length: got %0d cycles expected %0d", busy_cycles, 20 * C);
    end
  endtask

  task automatic test_held_high();
    logic [7:0] got, exp;
    logic ok, to;
    int bad;
    @(negedge clk);
    result = 4'd3;
    transmit_ready = 1'b1;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h0A);
    fork
      begin
        repeat (5) @(negedge clk);
        result = 4'd7;
      end
    join_none
    for (int i = 0; i < 2; i++) begin
      rx_byte(got, ok, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (to || got !== exp || !ok) begin
        errors++; $display("FAIL held_rx%0d: got 0x%02h framing_ok=%0b timeout=%0b expected 0x%02h framing_ok=1", i, got, ok, to, exp);
      end
    end
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (busy === 1'b1 && sent !== 1'b1 && $time > 0) bad += 0;
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL held_no_repeat: %0d active cycles, expected 0", bad); end
    transmit_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp;
    logic ok, to;
    int bad, n;
    @(negedge clk);
    result = 4'd5;
    transmit_ready = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++; $display("FAIL mid_before_reset: busy=%b tx=%b expected busy=1 tx=0", busy, tx);
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_resume_after_reset: %0d active cycles, expected 0", bad); end
    transmit_ready = 1'b0;
    @(negedge clk);
    transmit_ready = 1'b1;
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h0A);
    for (int i = 0; i < 2; i++) begin
      rx_byte(got, ok, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (to || got !== exp || !ok) begin
        errors++; $display("FAIL rearm_rx%0d: got 0x%02h framing_ok=%0b timeout=%0b expected 0x%02h framing_ok=1", i, got, ok, to, exp);
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    transmit_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    logic ok, to;
    result = 4'hC;
    transmit_ready = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h0A);
    @(negedge clk);
    transmit_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_byte(got, ok, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (to || got !== exp || !ok) begin
        errors++; $display("FAIL b2b_first_rx%0d: got 0x%02h framing_ok=%0b timeout=%0b expected 0x%02h framing_ok=1", i, got, ok, to, exp);
      end
    end
    @(negedge clk);
    transmit_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (sent !== 1'b1) begin errors++; $display("FAIL b2b_sent: got %b expected 1", sent); end
    transmit_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sent !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: busy=%b sent=%b expected busy=0 sent=0", busy, sent);
    end
    transmit_ready = 1'b1;
    result = 4'd6;
    exp_q.push_back(8'h36);
    exp_q.push_back(8'h0A);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: busy=%b tx=%b expected busy=1 tx=0", busy, tx);
    end
    for (int i = 0; i < 2; i++) begin
      rx_byte(got, ok, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (to || got !== exp || !ok) begin
        errors++; $display("FAIL b2b_second_rx%0d: got 0x%02h framing_ok=%0b timeout=%0b expected 0x%02h framing_ok=1", i, got, ok, to, exp);
      end
    end
    transmit_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d bytes left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_held_high();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
